// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Hardwired multi-cycle control sequencer. Steps through a
//                common fetch (T0-T2), then decodes ir[31:27] and issues the
//                per-instruction datapath strobes for T3-T7. HALT parks the
//                machine until clr.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [4:0]  alu_control,
  output logic        MDROut,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHIout,
  output logic        ZLOout,
  output logic        Pout,
  output logic        Cout,
  output logic        Yout,
  output logic        Rout,
  output logic        BAout,
  output logic        IRen,
  output logic        MARen,
  output logic        MDRen,
  output logic        Yen,
  output logic        Pen,
  output logic        ZHIen,
  output logic        ZLOen,
  output logic        Zen,
  output logic        HIen,
  output logic        LOen,
  output logic        Rin,
  output logic        ConIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic        run
);

  // State encoding
  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  // Opcodes that are referenced individually
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU codes used for address math and the immediate logic ops
  localparam logic [4:0] ALU_INC = 5'b11111;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [4:0] w_op;
  logic       w_is_rr;
  logic       w_is_imm;
  logic       w_is_mem;
  logic       w_is_muldiv;
  logic       w_is_negnot;
  logic [4:0] w_imm_alu;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  // Instruction classes sharing a step pattern
  assign w_is_rr     = (w_op >= 5'b00011) && (w_op <= 5'b01011);
  assign w_is_imm    = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
  assign w_is_mem    = (w_op == OP_LD) || (w_op == OP_LDI) || (w_op == OP_ST);
  assign w_is_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_is_negnot = (w_op == OP_NEG) || (w_op == OP_NOT);
  assign w_imm_alu   = (w_op == OP_ANDI) ? ALU_AND :
                       (w_op == OP_ORI)  ? ALU_OR  : ALU_ADD;

  // State register; clr overrides everything, including HALT
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_RST;
    else     r_state <= w_next_state;
  end

  // Next-state: each instruction returns to T0 after its last step
  always_comb begin
    w_next_state = S_RST;
    case (r_state)
      S_RST:  w_next_state = S_T0;
      S_T0:   w_next_state = S_T1;
      S_T1:   w_next_state = S_T2;
      S_T2:   w_next_state = S_T3;
      S_T3: begin
        if (w_op == OP_HALT)
          w_next_state = S_HALT;
        else if (w_is_rr || w_is_imm || w_is_mem || w_is_muldiv || w_is_negnot ||
                 w_op == OP_BR || w_op == OP_JAL)
          w_next_state = S_T4;
        else
          w_next_state = S_T0;
      end
      S_T4: begin
        if (w_is_negnot || w_op == OP_JAL) w_next_state = S_T0;
        else                               w_next_state = S_T5;
      end
      S_T5: begin
        if (w_op == OP_LD || w_op == OP_ST || w_is_muldiv || w_op == OP_BR)
          w_next_state = S_T6;
        else
          w_next_state = S_T0;
      end
      S_T6: begin
        if (w_op == OP_LD || w_op == OP_ST) w_next_state = S_T7;
        else                                w_next_state = S_T0;
      end
      S_T7:   w_next_state = S_T0;
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_RST;
    endcase
  end

  // Output decode from state and opcode; everything defaults low
  always_comb begin
    alu_control = 5'b00000;
    MDROut = 1'b0; HIout = 1'b0; LOout = 1'b0; ZHIout = 1'b0; ZLOout = 1'b0;
    Pout   = 1'b0; Cout  = 1'b0; Yout  = 1'b0; Rout   = 1'b0; BAout  = 1'b0;
    IRen   = 1'b0; MARen = 1'b0; MDRen = 1'b0; Yen    = 1'b0; Pen    = 1'b0;
    ZHIen  = 1'b0; ZLOen = 1'b0; Zen   = 1'b0; HIen   = 1'b0; LOen   = 1'b0;
    Rin    = 1'b0; ConIn = 1'b0;
    Gra    = 1'b0; Grb   = 1'b0; Grc   = 1'b0;
    Read   = 1'b0; Write = 1'b0;
    run    = (r_state != S_HALT);
    case (r_state)
      S_T0: begin Pout = 1'b1; MARen = 1'b1; alu_control = ALU_INC; Zen = 1'b1; end
      S_T1: begin ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1; end
      S_T2: begin MDROut = 1'b1; IRen = 1'b1; end
      S_T3: begin
        if (w_is_rr || w_is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yen = 1'b1;
        end else if (w_is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yen = 1'b1;
        end else if (w_is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yen = 1'b1;
        end else if (w_is_negnot) begin
          Grb = 1'b1; Rout = 1'b1; alu_control = w_op; Zen = 1'b1;
        end else if (w_op == OP_BR) begin
          Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1;
        end else if (w_op == OP_JR) begin
          Gra = 1'b1; Rout = 1'b1; Pen = 1'b1;
        end else if (w_op == OP_JAL) begin
          Pout = 1'b1; Grb = 1'b1; Rin = 1'b1;
        end else if (w_op == OP_MFHI) begin
          HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_op == OP_MFLO) begin
          LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T4: begin
        if (w_is_rr) begin
          Grc = 1'b1; Rout = 1'b1; alu_control = w_op; Zen = 1'b1;
        end else if (w_is_imm) begin
          Cout = 1'b1; alu_control = w_imm_alu; Zen = 1'b1;
        end else if (w_is_mem) begin
          Cout = 1'b1; alu_control = ALU_ADD; Zen = 1'b1;
        end else if (w_is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; alu_control = w_op; Zen = 1'b1;
        end else if (w_is_negnot) begin
          ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_op == OP_BR) begin
          Pout = 1'b1; Yen = 1'b1;
        end else if (w_op == OP_JAL) begin
          Gra = 1'b1; Rout = 1'b1; Pen = 1'b1;
        end
      end
      S_T5: begin
        if (w_is_rr || w_is_imm || w_op == OP_LDI) begin
          ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_op == OP_LD || w_op == OP_ST) begin
          ZLOout = 1'b1; MARen = 1'b1;
        end else if (w_is_muldiv) begin
          ZLOout = 1'b1; LOen = 1'b1;
        end else if (w_op == OP_BR) begin
          Cout = 1'b1; alu_control = ALU_ADD; Zen = 1'b1;
        end
      end
      S_T6: begin
        if (w_op == OP_LD) begin
          Read = 1'b1; MDRen = 1'b1;
        end else if (w_op == OP_ST) begin
          // Source register goes onto the bus into MDR; no memory read here
          Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1;
        end else if (w_is_muldiv) begin
          ZHIout = 1'b1; HIen = 1'b1;
        end else if (w_op == OP_BR) begin
          ZLOout = 1'b1; Pen = con_ff;
        end
      end
      S_T7: begin
        if (w_op == OP_LD) begin
          MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_op == OP_ST) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Directed, table-driven bench for control_unit plus hand
//                sequences for halt and mid-sequence reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = 32'd0;
  logic        con_ff = 1'b0;
  logic [4:0]  alu_control;
  logic MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout, Rout, BAout;
  logic IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, Zen, HIen, LOen, Rin, ConIn;
  logic Gra, Grb, Grc, Read, Write, run;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .alu_control(alu_control),
    .MDROut(MDROut), .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout),
    .Pout(Pout), .Cout(Cout), .Yout(Yout), .Rout(Rout), .BAout(BAout),
    .IRen(IRen), .MARen(MARen), .MDRen(MDRen), .Yen(Yen), .Pen(Pen),
    .ZHIen(ZHIen), .ZLOen(ZLOen), .Zen(Zen), .HIen(HIen), .LOen(LOen),
    .Rin(Rin), .ConIn(ConIn), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Read(Read), .Write(Write), .run(run)
  );

  // Output vector layout: [32:28] alu, [27:18] bus drives, [17:6] enables,
  // [5:3] Gra/Grb/Grc, [2] Read, [1] Write, [0] run
  localparam logic [32:0] M_RUN    = 33'd1 << 0;
  localparam logic [32:0] M_WRITE  = 33'd1 << 1;
  localparam logic [32:0] M_READ   = 33'd1 << 2;
  localparam logic [32:0] M_GRC    = 33'd1 << 3;
  localparam logic [32:0] M_GRB    = 33'd1 << 4;
  localparam logic [32:0] M_GRA    = 33'd1 << 5;
  localparam logic [32:0] M_CONIN  = 33'd1 << 6;
  localparam logic [32:0] M_RIN    = 33'd1 << 7;
  localparam logic [32:0] M_LOEN   = 33'd1 << 8;
  localparam logic [32:0] M_HIEN   = 33'd1 << 9;
  localparam logic [32:0] M_ZEN    = 33'd1 << 10;
  localparam logic [32:0] M_PEN    = 33'd1 << 13;
  localparam logic [32:0] M_YEN    = 33'd1 << 14;
  localparam logic [32:0] M_MDREN  = 33'd1 << 15;
  localparam logic [32:0] M_MAREN  = 33'd1 << 16;
  localparam logic [32:0] M_IREN   = 33'd1 << 17;
  localparam logic [32:0] M_BAOUT  = 33'd1 << 18;
  localparam logic [32:0] M_ROUT   = 33'd1 << 19;
  localparam logic [32:0] M_COUT   = 33'd1 << 21;
  localparam logic [32:0] M_POUT   = 33'd1 << 22;
  localparam logic [32:0] M_ZLOOUT = 33'd1 << 23;
  localparam logic [32:0] M_ZHIOUT = 33'd1 << 24;
  localparam logic [32:0] M_LOOUT  = 33'd1 << 25;
  localparam logic [32:0] M_HIOUT  = 33'd1 << 26;
  localparam logic [32:0] M_MDROUT = 33'd1 << 27;

  function automatic logic [32:0] alu(input logic [4:0] c);
    return {c, 28'd0};
  endfunction

  function automatic logic [32:0] pack();
    return {alu_control,
            MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout, Rout, BAout,
            IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, Zen, HIen, LOen, Rin, ConIn,
            Gra, Grb, Grc, Read, Write, run};
  endfunction

  task automatic check(input string name, input logic [32:0] exp);
    logic [32:0] obs;
    obs = pack();
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: outputs got %h expected %h", name, obs, exp);
    end
    tests++;
    if ((Read && Write) || !$onehot0(obs[27:18])) begin
      failed++;
      $display("FAIL %s_excl: Read/Write or bus drives overlap, got %h", name, obs);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        con_ff;
    int          k;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [4:0] op, input logic cf,
                     input int k, input logic [32:0] e);
    vec_t v;
    v.name = n; v.ir = {op, 27'h0012345}; v.con_ff = cf; v.k = k; v.exp = e;
    vecs.push_back(v);
  endtask

  // Reset, release, then sample k cycles after T0 on the falling edge
  task automatic run_vec(input vec_t v);
    ir = v.ir; con_ff = v.con_ff;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    repeat (v.k) @(posedge clk);
    @(negedge clk);
    check(v.name, v.exp);
  endtask

  task automatic go_t0();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
  endtask

  logic mon_hi = 1'b0;
  logic hi_seen = 1'b0;
  always @(negedge clk) if (mon_hi && HIen) hi_seen <= 1'b1;

  logic [32:0] F0;

  initial begin
    F0 = M_POUT | M_MAREN | M_ZEN | alu(5'b11111) | M_RUN;

    // Reset then fetch in consecutive cycles
    clr = 1'b1; ir = 32'h18000000;
    repeat (2) @(posedge clk);
    @(negedge clk); check("rst_state", M_RUN);
    clr = 1'b0;
    @(posedge clk); @(negedge clk); check("fetch_t0", F0);
    @(posedge clk); @(negedge clk); check("fetch_t1", M_ZLOOUT | M_PEN | M_READ | M_MDREN | M_RUN);
    @(posedge clk); @(negedge clk); check("fetch_t2", M_MDROUT | M_IREN | M_RUN);
    @(posedge clk); @(negedge clk); check("fetch_t3_add", M_GRB | M_ROUT | M_YEN | M_RUN);

    add("add_t4",   5'b00011, 0, 4, M_GRC | M_ROUT | alu(5'b00011) | M_ZEN | M_RUN);
    add("add_t5",   5'b00011, 0, 5, M_ZLOOUT | M_GRA | M_RIN | M_RUN);
    add("add_t0",   5'b00011, 0, 6, F0);
    add("shl_t4",   5'b01011, 0, 4, M_GRC | M_ROUT | alu(5'b01011) | M_ZEN | M_RUN);
    add("addi_t4",  5'b01100, 0, 4, M_COUT | alu(5'b00011) | M_ZEN | M_RUN);
    add("andi_t4",  5'b01101, 0, 4, M_COUT | alu(5'b00101) | M_ZEN | M_RUN);
    add("ori_t4",   5'b01110, 0, 4, M_COUT | alu(5'b00110) | M_ZEN | M_RUN);
    add("ori_t5",   5'b01110, 0, 5, M_ZLOOUT | M_GRA | M_RIN | M_RUN);
    add("ld_t3",    5'b00000, 0, 3, M_GRB | M_BAOUT | M_YEN | M_RUN);
    add("ld_t4",    5'b00000, 0, 4, M_COUT | alu(5'b00011) | M_ZEN | M_RUN);
    add("ld_t5",    5'b00000, 0, 5, M_ZLOOUT | M_MAREN | M_RUN);
    add("ld_t6",    5'b00000, 0, 6, M_READ | M_MDREN | M_RUN);
    add("ld_t7",    5'b00000, 0, 7, M_MDROUT | M_GRA | M_RIN | M_RUN);
    add("ld_t0",    5'b00000, 0, 8, F0);
    add("ldi_t5",   5'b00001, 0, 5, M_ZLOOUT | M_GRA | M_RIN | M_RUN);
    add("ldi_t0",   5'b00001, 0, 6, F0);
    add("st_t5",    5'b00010, 0, 5, M_ZLOOUT | M_MAREN | M_RUN);
    add("st_t6",    5'b00010, 0, 6, M_GRA | M_ROUT | M_MDREN | M_RUN);
    add("st_t7",    5'b00010, 0, 7, M_WRITE | M_RUN);
    add("st_t0",    5'b00010, 0, 8, F0);
    add("mul_t3",   5'b10000, 0, 3, M_GRA | M_ROUT | M_YEN | M_RUN);
    add("mul_t4",   5'b10000, 0, 4, M_GRB | M_ROUT | alu(5'b10000) | M_ZEN | M_RUN);
    add("mul_t5",   5'b10000, 0, 5, M_ZLOOUT | M_LOEN | M_RUN);
    add("mul_t6",   5'b10000, 0, 6, M_ZHIOUT | M_HIEN | M_RUN);
    add("mul_t0",   5'b10000, 0, 7, F0);
    add("div_t4",   5'b01111, 0, 4, M_GRB | M_ROUT | alu(5'b01111) | M_ZEN | M_RUN);
    add("neg_t3",   5'b10001, 0, 3, M_GRB | M_ROUT | alu(5'b10001) | M_ZEN | M_RUN);
    add("neg_t4",   5'b10001, 0, 4, M_ZLOOUT | M_GRA | M_RIN | M_RUN);
    add("neg_t0",   5'b10001, 0, 5, F0);
    add("not_t3",   5'b10010, 0, 3, M_GRB | M_ROUT | alu(5'b10010) | M_ZEN | M_RUN);
    add("br_t3",    5'b10011, 0, 3, M_GRA | M_ROUT | M_CONIN | M_RUN);
    add("br_t4",    5'b10011, 0, 4, M_POUT | M_YEN | M_RUN);
    add("br_t5",    5'b10011, 0, 5, M_COUT | alu(5'b00011) | M_ZEN | M_RUN);
    add("br_t6_c0", 5'b10011, 0, 6, M_ZLOOUT | M_RUN);
    add("br_t6_c1", 5'b10011, 1, 6, M_ZLOOUT | M_PEN | M_RUN);
    add("br_t0",    5'b10011, 1, 7, F0);
    add("jr_t3",    5'b10100, 0, 3, M_GRA | M_ROUT | M_PEN | M_RUN);
    add("jr_t0",    5'b10100, 0, 4, F0);
    add("jal_t3",   5'b10101, 0, 3, M_POUT | M_GRB | M_RIN | M_RUN);
    add("jal_t4",   5'b10101, 0, 4, M_GRA | M_ROUT | M_PEN | M_RUN);
    add("jal_t0",   5'b10101, 0, 5, F0);
    add("mfhi_t3",  5'b11000, 0, 3, M_HIOUT | M_GRA | M_RIN | M_RUN);
    add("mflo_t3",  5'b11001, 0, 3, M_LOOUT | M_GRA | M_RIN | M_RUN);
    add("mflo_t0",  5'b11001, 0, 4, F0);
    add("nop_t3",   5'b11010, 0, 3, M_RUN);
    add("nop_t0",   5'b11010, 0, 4, F0);
    add("op16_t0",  5'b10110, 0, 4, F0);
    add("op1f_t3",  5'b11111, 0, 3, M_RUN);
    add("op1f_t0",  5'b11111, 0, 4, F0);
    add("halt_t3",  5'b11011, 0, 3, M_RUN);
    add("halt_st",  5'b11011, 0, 4, 33'd0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Halt holds run low until clr, then RST and a fresh fetch
    ir = 32'hD8000000;
    go_t0();
    repeat (4) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); check($sformatf("halt_hold%0d", i), 33'd0);
      @(posedge clk);
    end
    @(negedge clk); clr = 1'b1;
    @(posedge clk); @(negedge clk); check("halt_clr_rst", M_RUN);
    clr = 1'b0;
    @(posedge clk); @(negedge clk); check("halt_clr_t0", F0);

    // clr during mul T5 aborts before the HI write
    ir = 32'h80000000;
    go_t0();
    mon_hi = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); check("abort_mul_t5", M_ZLOOUT | M_LOEN | M_RUN);
    clr = 1'b1;
    @(posedge clk); @(negedge clk); check("abort_rst", M_RUN);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_hi = 1'b0;
    tests++;
    if (hi_seen !== 1'b0) begin
      failed++;
      $display("FAIL abort_no_hien: HIen seen %b expected 0", hi_seen);
    end
    clr = 1'b0;
    @(posedge clk); @(negedge clk); check("abort_t0", F0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
